// File: rtl/single_midi_out.sv
// MIDI 8N1 transmitter: handshake FIFO, optional running-status
// compression, LSB-first serialiser with registered line output.
module single_midi_out #(
  parameter int BYTE_W         = 8,
  parameter int MIDI_BAUD      = 31250,
  parameter int SYSCLK_F       = 48000000,
  parameter int FIFO_DEPTH     = 4,
  parameter int RUNNING_STATUS = 1
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [BYTE_W-1:0]             data_tx,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          MIDI_OUT,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sent_strobe
);

  localparam int CLKS_PER_BIT = SYSCLK_F / MIDI_BAUD;
  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BIT_W = $clog2(BYTE_W);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE =
    CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic               midi_q, midi_d;
  logic               sent_q, sent_d;
  logic [BYTE_W-1:0]  ls_q, ls_d;
  logic               ls_vld_q, ls_vld_d;

  logic [BYTE_W-1:0]  mem_q [FIFO_DEPTH];
  logic [BYTE_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;

  logic               full;
  logic               push;
  logic               pop;
  logic [BYTE_W-1:0]  head;
  logic [3:0]         hi;
  logic               is_chan;
  logic               is_common;
  logic               drop;

  assign full     = (lvl_q == LVL_FULL);
  assign tx_ready = !full;
  assign push     = tx_valid && !full;
  assign pop      = (state_q == IDLE) && (lvl_q != '0);
  assign head     = mem_q[rd_q];

  // Classify the FIFO head: channel-voice status or system common.
  assign hi        = head[BYTE_W-1 -: 4];
  assign is_chan   = head[BYTE_W-1] && (hi != 4'hF);
  assign is_common = (hi == 4'hF) && !head[BYTE_W-5];
  assign drop      = (RUNNING_STATUS != 0) && is_chan &&
                     ls_vld_q && (head == ls_q);

  assign MIDI_OUT    = midi_q;
  assign sent_strobe = sent_q;
  assign fifo_level  = lvl_q;
  assign busy        = (state_q != IDLE) || (lvl_q != '0);

  // FIFO pointer, storage and occupancy next-state.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push) begin
      mem_d[wr_q] = data_tx;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  // Frame sequencer, running-status tracking and line driver.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    midi_d   = midi_q;
    sent_d   = 1'b0;
    ls_d     = ls_q;
    ls_vld_d = ls_vld_q;
    case (state_q)
      IDLE: begin
        midi_d = 1'b1;
        if (pop) begin
          unique case (1'b1)
            is_chan: begin
              ls_d     = head;
              ls_vld_d = 1'b1;
            end
            is_common: ls_vld_d = 1'b0;
            default: ;
          endcase
          if (!drop) begin
            shift_d = head;
            state_d = START;
            cnt_d   = '0;
            midi_d  = 1'b0;
          end
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          midi_d  = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            midi_d  = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            midi_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        midi_d = 1'b1;
        sent_d = (cnt_q == CNT_PRE);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        midi_d  = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any frame and idles the line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      midi_q   <= 1'b1;
      sent_q   <= 1'b0;
      ls_q     <= '0;
      ls_vld_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      midi_q   <= midi_d;
      sent_q   <= sent_d;
      ls_q     <= ls_d;
      ls_vld_q <= ls_vld_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      lvl_q    <= lvl_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_single_midi_out.sv
// Bench for single_midi_out at 16 clocks per bit:
// table of byte streams plus timing and reset sequences.
module tb_single_midi_out;

  localparam int C = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_valid, a_ready, a_out, a_busy, a_strobe;
  logic [7:0] a_data;
  logic [2:0] a_level;
  logic       b_rst_n, b_valid, b_ready, b_out, b_busy, b_strobe;
  logic [7:0] b_data;
  logic [2:0] b_level;

  single_midi_out #(
    .BYTE_W(8), .MIDI_BAUD(31250), .SYSCLK_F(500000),
    .FIFO_DEPTH(4), .RUNNING_STATUS(1)
  ) dut_a (
    .sys_clk(clk), .sys_rst_n(a_rst_n), .data_tx(a_data),
    .tx_valid(a_valid), .tx_ready(a_ready), .MIDI_OUT(a_out),
    .busy(a_busy), .fifo_level(a_level),
    .sent_strobe(a_strobe)
  );

  single_midi_out #(
    .BYTE_W(8), .MIDI_BAUD(31250), .SYSCLK_F(500000),
    .FIFO_DEPTH(4), .RUNNING_STATUS(0)
  ) dut_b (
    .sys_clk(clk), .sys_rst_n(b_rst_n), .data_tx(b_data),
    .tx_valid(b_valid), .tx_ready(b_ready), .MIDI_OUT(b_out),
    .busy(b_busy), .fifo_level(b_level),
    .sent_strobe(b_strobe)
  );

  int cyc  = 0;
  int a_sc = 0;
  int b_sc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_strobe === 1'b1) a_sc <= a_sc + 1;
    if (b_strobe === 1'b1) b_sc <= b_sc + 1;
  end

  bit   sel = 1'b0;
  logic mon_line;
  assign mon_line = sel ? b_out : a_out;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    a_rst_n = 1'b0;
    a_valid = 1'b0;
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called on a negedge; returns on a negedge after acceptance.
  task automatic push_a(input logic [7:0] v);
    int w;
    w = 0;
    a_data  = v;
    a_valid = 1'b1;
    while (a_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) check("push_timeout", 1, 0);
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
  endtask

  // Wait for a start bit on the monitored line, sample mid-bit.
  task automatic rx(output logic [7:0] v, output bit ok,
                    output int t_fall);
    int w;
    w  = 0;
    v  = '0;
    ok = 1'b1;
    while (mon_line !== 1'b0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    t_fall = cyc;
    if (w >= 5000) begin
      ok = 1'b0;
      check("rx_timeout", 1, 0);
      return;
    end
    repeat (C / 2) @(negedge clk);
    if (mon_line !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      v[i] = mon_line;
    end
    repeat (C) @(negedge clk);
    if (mon_line !== 1'b1) ok = 1'b0;
  endtask

  typedef struct {
    int         n_in;
    logic [7:0] in_b [8];
    int         n_out;
    logic [7:0] out_b [8];
  } vec_t;

  vec_t tbl [5];

  logic [7:0] got;
  bit         ok;
  int         tf, t0, t1, s0, w, e, acc, sixth;
  logic       r;
  logic [7:0] pat;
  logic       exp_bit;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, '{8'h90, 0, 0, 0, 0, 0, 0, 0},
               1, '{8'h90, 0, 0, 0, 0, 0, 0, 0}};
    tbl[1] = '{6, '{8'h90, 8'h3C, 8'h40, 8'h90,
                    8'h3E, 8'h00, 0, 0},
               5, '{8'h90, 8'h3C, 8'h40, 8'h3E,
                    8'h00, 0, 0, 0}};
    tbl[2] = '{7, '{8'h90, 8'h3C, 8'h40, 8'hF8,
                    8'h90, 8'h3E, 8'h00, 0},
               6, '{8'h90, 8'h3C, 8'h40, 8'hF8,
                    8'h3E, 8'h00, 0, 0}};
    tbl[3] = '{4, '{8'h90, 8'h3C, 8'hF0, 8'h90,
                    0, 0, 0, 0},
               4, '{8'h90, 8'h3C, 8'hF0, 8'h90,
                    0, 0, 0, 0}};
    tbl[4] = '{8, '{8'hB0, 8'h07, 8'h7F, 8'hB0,
                    8'h07, 8'h00, 8'hC0, 8'h05},
               7, '{8'hB0, 8'h07, 8'h7F, 8'h07,
                    8'h00, 8'hC0, 8'h05, 0}};

    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;
    repeat (3) @(negedge clk);

    // Reset state while held in reset.
    check("rst_line",   a_out,    1);
    check("rst_ready",  a_ready,  1);
    check("rst_busy",   a_busy,   0);
    check("rst_level",  a_level,  0);
    check("rst_strobe", a_strobe, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(negedge clk);

    // Exact frame shape and strobe position for 0x90.
    sel = 1'b0;
    s0  = a_sc;
    a_data  = 8'h90;
    a_valid = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (a_out !== 1'b0 && w < 100);
    check("start_latency", w, 2);
    pat = 8'h90;
    e   = 0;
    for (int i = 0; i < 10 * C; i++) begin
      if (i < C) exp_bit = 1'b0;
      else if (i < 9 * C) exp_bit = pat[(i / C) - 1];
      else exp_bit = 1'b1;
      if (a_out !== exp_bit) e++;
      if (a_strobe !== (i == 10 * C - 1)) e++;
      if (i == 5 * C) check("busy_mid_frame", a_busy, 1);
      @(negedge clk);
    end
    check("frame_shape_errs", e, 0);
    check("t1_idle_line", a_out, 1);
    check("t1_strobes", a_sc - s0, 1);
    @(negedge clk);
    check("t1_idle_busy", a_busy, 0);

    // Table of byte streams through the running-status DUT.
    for (int v = 0; v < 5; v++) begin
      reset_a();
      s0 = a_sc;
      fork
        begin
          for (int i = 0; i < tbl[v].n_in; i++)
            push_a(tbl[v].in_b[i]);
        end
        begin
          for (int j = 0; j < tbl[v].n_out; j++) begin
            rx(got, ok, tf);
            check($sformatf("v%0d_byte%0d", v, j),
                  got, tbl[v].out_b[j]);
            check($sformatf("v%0d_frame%0d", v, j), ok, 1);
          end
        end
      join
      repeat (2 * C) @(negedge clk);
      check($sformatf("v%0d_strobes", v),
            a_sc - s0, tbl[v].n_out);
      check($sformatf("v%0d_busy", v), a_busy, 0);
      check($sformatf("v%0d_level", v), a_level, 0);
    end

    // Hold tx_valid with 7 bytes across reset release.
    @(negedge clk);
    a_rst_n = 1'b0;
    a_data  = 8'h00;
    a_valid = 1'b1;
    @(negedge clk);
    a_rst_n = 1'b1;
    s0    = a_sc;
    acc   = 0;
    sixth = -1;
    w     = 0;
    while (acc < 7 && w < 3000) begin
      if (w == 3 * C) begin
        check("hold_accepted", acc, 5);
        check("hold_ready", a_ready, 0);
        check("hold_level", a_level, 4);
      end
      r = a_ready;
      @(posedge clk);
      if (r === 1'b1) begin
        acc++;
        if (acc == 6) sixth = a_sc - s0;
        #1;
        a_data = 8'(acc);
        if (acc == 7) a_valid = 1'b0;
      end
      @(negedge clk);
      w++;
    end
    a_valid = 1'b0;
    check("hold_total", acc, 7);
    check("hold_sixth_after_frame", (sixth >= 1), 1);
    w = 0;
    while (a_sc - s0 < 7 && w < 8000) begin
      @(negedge clk);
      w++;
    end
    check("hold_strobes", a_sc - s0, 7);
    repeat (4) @(negedge clk);
    check("hold_busy", a_busy, 0);

    // Reset in the middle of data bit 3.
    reset_a();
    a_data  = 8'h90;
    a_valid = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (a_out !== 1'b0 && w < 100);
    push_a(8'h3C);
    push_a(8'h40);
    repeat (C + 3 * C + C / 2 - 4) @(negedge clk);
    check("mid_bit3_line", a_out, 0);
    check("mid_bit3_level", a_level, 2);
    a_rst_n = 1'b0;
    #1;
    check("abort_line", a_out, 1);
    check("abort_level", a_level, 0);
    check("abort_busy", a_busy, 0);
    check("abort_ready", a_ready, 1);
    @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
    s0 = a_sc;
    push_a(8'h90);
    rx(got, ok, tf);
    check("after_abort_byte", got, 8'h90);
    check("after_abort_frame", ok, 1);
    repeat (2 * C) @(negedge clk);
    check("after_abort_strobes", a_sc - s0, 1);

    // No compression: 90 90 back to back, C+1 high between.
    sel = 1'b1;
    s0  = b_sc;
    @(negedge clk);
    b_data  = 8'h90;
    b_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 b_valid = 1'b0;
    @(negedge clk);
    rx(got, ok, t0);
    check("nrs_byte0", got, 8'h90);
    check("nrs_frame0", ok, 1);
    rx(got, ok, t1);
    check("nrs_byte1", got, 8'h90);
    check("nrs_frame1", ok, 1);
    check("nrs_spacing", t1 - t0, 10 * C + 1);
    repeat (2 * C) @(negedge clk);
    check("nrs_strobes", b_sc - s0, 2);
    check("nrs_busy", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
